// File: rtl/dma_line_unpacker.sv
// dma_line_unpacker: pops 512-bit cache lines from a first-word-fall-through
// DMA read FIFO and replays them as a stream of OUT_WIDTH-bit words, one
// 32-bit slot per handshake, slot 0 first. A software-supplied line count is
// consumed per go. Completion and upper-bit truncation are reported as sticky
// flags.
//
// Output stream handshake: a word transfers on every rising clk edge where
// out_valid && out_ready. Once out_valid is raised, out_data holds the same
// word until that transfer happens. out_valid never depends combinationally
// on out_ready.
module dma_line_unpacker #(
  parameter int CL_DATA_WIDTH = 512,
  parameter int SLOT_WIDTH    = 32,
  parameter int OUT_WIDTH     = 20,   // must not exceed SLOT_WIDTH
  parameter int COUNT_WIDTH   = 65
) (
  input  logic                     clk,
  input  logic                     rst,          // asynchronous, active low
  input  logic                     go,
  input  logic [COUNT_WIDTH-1:0]   num_lines,
  input  logic                     dma_empty,
  input  logic [CL_DATA_WIDTH-1:0] dma_rd_data,
  output logic                     dma_rd_en,
  output logic                     out_valid,
  output logic [OUT_WIDTH-1:0]     out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     trunc_err,
  output logic [1:0]               dbg_state     // FSM state, for observation
);

  localparam int SLOTS = CL_DATA_WIDTH / SLOT_WIDTH;
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Registered state and its next-state values.
  state_e                   state_q,      state_d;
  logic [COUNT_WIDTH-1:0]   lines_left_q, lines_left_d;   // lines not yet popped
  logic [CL_DATA_WIDTH-1:0] line_q,       line_d;         // current line buffer
  logic                     line_vld_q,   line_vld_d;     // buffer has unsent slots
  logic [IDX_W-1:0]         slot_idx_q,   slot_idx_d;     // next slot to emit
  logic                     trunc_q,      trunc_d;

  // Combinational helpers.
  logic [SLOT_WIDTH-1:0] slot_arr [SLOTS];
  logic [SLOT_WIDTH-1:0] cur_slot;
  logic                  cur_upper_nz;
  logic                  handshake;
  logic                  last_handshake;
  logic                  pop;

  // Split the buffered line into slots; slot k sits at bits [32k+31:32k].
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      slot_arr[k] = line_q[k*SLOT_WIDTH +: SLOT_WIDTH];
    end
  end

  // Select the slot being presented and derive handshake / pop conditions.
  always_comb begin
    cur_slot       = slot_arr[slot_idx_q];
    // Any bit above the emitted width is lost when the slot is narrowed.
    cur_upper_nz   = (cur_slot >> OUT_WIDTH) != '0;
    handshake      = line_vld_q && out_ready;
    last_handshake = handshake && (slot_idx_q == LAST_IDX);
    // Refill when the buffer is empty, or exactly as its last slot leaves so
    // consecutive lines stream without a bubble.
    pop            = (state_q == S_RUN) && !dma_empty &&
                     (lines_left_q != '0) &&
                     (!line_vld_q || last_handshake);
  end

  // Next-state logic for the FSM, buffer, counters and sticky flag.
  always_comb begin
    state_d      = state_q;
    lines_left_d = lines_left_q;
    line_d       = line_q;
    line_vld_d   = line_vld_q;
    slot_idx_d   = slot_idx_q;
    trunc_d      = trunc_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          lines_left_d = num_lines;
          trunc_d      = 1'b0;
          line_vld_d   = 1'b0;
          slot_idx_d   = '0;
          state_d      = (num_lines == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        // go is deliberately ignored while a transfer is running.
        if (handshake && cur_upper_nz) begin
          trunc_d = 1'b1;
        end

        if (pop) begin
          line_d       = dma_rd_data;
          line_vld_d   = 1'b1;
          slot_idx_d   = '0;
          lines_left_d = lines_left_q - CNT_ONE;
        end else if (last_handshake) begin
          line_vld_d = 1'b0;
        end else if (handshake) begin
          slot_idx_d = slot_idx_q + IDX_W'(1);
        end

        // lines_left already counts only unpopped lines, so zero here means
        // the word just accepted was the final one of the transfer.
        if (last_handshake && (lines_left_q == '0)) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low clear; a reset drops any
  // partially sent line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lines_left_q <= '0;
      line_q       <= '0;
      line_vld_q   <= 1'b0;
      slot_idx_q   <= '0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lines_left_q <= lines_left_d;
      line_q       <= line_d;
      line_vld_q   <= line_vld_d;
      slot_idx_q   <= slot_idx_d;
      trunc_q      <= trunc_d;
    end
  end

  // Outputs come from registered state only (dma_rd_en also sees inputs).
  always_comb begin
    dma_rd_en = pop;
    out_valid = line_vld_q;
    out_data  = cur_slot[OUT_WIDTH-1:0];
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    trunc_err = trunc_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_dma_line_unpacker.sv
// Directed bench for dma_line_unpacker: a queue-based DMA FIFO, a word-level
// reference model checked every cycle, and literal checks per scenario.
module tb_dma_line_unpacker;

  localparam int CLW  = 512;
  localparam int SW   = 32;
  localparam int OW   = 20;
  localparam int CW   = 65;
  localparam int NSLOT = CLW / SW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic            go = 1'b0;
  logic [CW-1:0]   num_lines = '0;
  logic            dma_empty = 1'b1;
  logic [CLW-1:0]  dma_rd_data = '0;
  logic            dma_rd_en;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            done;
  logic            trunc_err;
  logic [1:0]      dbg_state;

  dma_line_unpacker #(
    .CL_DATA_WIDTH(CLW), .SLOT_WIDTH(SW), .OUT_WIDTH(OW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .num_lines(num_lines),
    .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .trunc_err(trunc_err), .dbg_state(dbg_state)
  );

  // Counters and scoreboard state
  int n_tests = 0;
  int n_fail  = 0;

  logic [CLW-1:0] line_q[$];      // DMA FIFO contents, head first
  logic           pop_pending = 1'b0;
  logic           force_empty = 1'b0;
  logic           ready_mode  = 1'b0;  // 0: always ready, 1: toggle

  logic [SW-1:0]  exp_q[$];        // expected slots still to be emitted
  logic [OW-1:0]  obs_q[$];        // words actually accepted this scenario
  int             pops_seen = 0;
  int             m_out = 0;       // buffered, unsent words
  longint         m_req_left = 0;  // lines still to pop
  logic           m_active = 1'b0;
  logic           m_done = 1'b0;
  logic           m_trunc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CLW-1:0] make_line(input logic [SW-1:0] base);
    logic [CLW-1:0] l;
    l = '0;
    for (int k = 0; k < NSLOT; k++) l[k*SW +: SW] = base + SW'(k);
    return l;
  endfunction

  // DMA FIFO and consumer driver: applies pops and ready pattern after each edge.
  always @(posedge clk) begin
    #2;
    if (pop_pending && line_q.size() > 0) void'(line_q.pop_front());
    pop_pending = 1'b0;
    if (ready_mode) out_ready = ~out_ready;
    else            out_ready = 1'b1;
    dma_empty   = force_empty || (line_q.size() == 0);
    dma_rd_data = (line_q.size() > 0) ? line_q[0] : '0;
  end

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    logic          exp_valid;
    logic          exp_pop;
    logic          hs;
    logic          was_active;
    logic [SW-1:0] s;
    if (!rst) begin
      exp_q.delete();
      m_out = 0; m_req_left = 0; m_active = 0; m_done = 0; m_trunc = 0;
      pop_pending = 1'b0;
      check("rst_rd_en", 64'(dma_rd_en), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_busy",  64'(busy),      64'd0);
      check("rst_done",  64'(done),      64'd0);
      check("rst_trunc", 64'(trunc_err), 64'd0);
    end else begin
      exp_valid = (m_out > 0);
      exp_pop   = m_active && !dma_empty && (m_req_left != 0) &&
                  (m_out == 0 || (m_out == 1 && out_ready));
      check("rd_en", 64'(dma_rd_en), 64'(exp_pop));
      check("valid", 64'(out_valid), 64'(exp_valid));
      check("busy",  64'(busy),      64'(m_active));
      check("done",  64'(done),      64'(m_done));
      check("trunc", 64'(trunc_err), 64'(m_trunc));
      if (exp_valid && exp_q.size() > 0) begin
        s = exp_q[0];
        check("data", 64'(out_data), 64'(s[OW-1:0]));
      end

      pop_pending = dma_rd_en;
      if (dma_rd_en) pops_seen++;
      if (out_valid && out_ready) obs_q.push_back(out_data);

      was_active = m_active;
      hs = exp_valid && out_ready;
      if (hs) begin
        s = exp_q.pop_front();
        if ((s >> OW) != 0) m_trunc = 1'b1;
        m_out--;
      end
      if (exp_pop) begin
        for (int k = 0; k < NSLOT; k++) exp_q.push_back(dma_rd_data[k*SW +: SW]);
        m_out += NSLOT;
        m_req_left--;
      end
      if (m_active && hs && m_out == 0 && m_req_left == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
      if (go && !was_active) begin
        m_req_left = longint'(num_lines);
        m_trunc    = 1'b0;
        m_active   = (num_lines != 0);
        m_done     = (num_lines == 0);
      end
    end
  end

  // Driver tasks
  task automatic start(input int n);
    obs_q.delete();
    pops_seen = 0;
    @(posedge clk); #1;
    go = 1'b1; num_lines = CW'(n);
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk); c++;
    end
    check({name, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    int c = 0;
    while (pops_seen < n && c < budget) begin
      @(negedge clk); c++;
    end
    check({name, "_pop_timeout"}, 64'(pops_seen), 64'(n));
  endtask

  task automatic wait_words(input string name, input int n, input int budget);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin
      @(negedge clk); c++;
    end
    check({name, "_word_timeout"}, 64'(obs_q.size() >= n), 64'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    logic [CLW-1:0] l;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: one line, slot k = k
    line_q.push_back(make_line(32'h0));
    start(1);
    wait_done("t1", 100);
    check("t1_pops", 64'(pops_seen), 64'd1);
    check("t1_count", 64'(obs_q.size()), 64'd16);
    for (int k = 0; k < 16; k++)
      if (k < obs_q.size()) check("t1_word", 64'(obs_q[k]), 64'(k));
    check("t1_trunc", 64'(trunc_err), 64'd0);

    // 2: three lines back to back
    for (int i = 0; i < 3; i++) line_q.push_back(make_line(32'((i + 1) << 8)));
    start(3);
    wait_done("t2", 200);
    check("t2_pops", 64'(pops_seen), 64'd3);
    check("t2_count", 64'(obs_q.size()), 64'd48);
    if (obs_q.size() == 48) begin
      check("t2_w16", 64'(obs_q[16]), 64'h200);
      check("t2_w47", 64'(obs_q[47]), 64'h30F);
    end

    // 3: two lines, ready toggling
    ready_mode = 1'b1;
    line_q.push_back(make_line(32'h4000));
    line_q.push_back(make_line(32'h5000));
    start(2);
    wait_done("t3", 300);
    ready_mode = 1'b0;
    check("t3_pops", 64'(pops_seen), 64'd2);
    check("t3_count", 64'(obs_q.size()), 64'd32);
    if (obs_q.size() == 32) check("t3_w31", 64'(obs_q[31]), 64'h500F);

    // 4: DMA empty gap between lines
    line_q.push_back(make_line(32'h6000));
    start(2);
    wait_pops("t4a", 1, 50);
    repeat (26) @(posedge clk);
    #1 line_q.push_back(make_line(32'h7000));
    wait_done("t4", 200);
    check("t4_pops", 64'(pops_seen), 64'd2);
    check("t4_count", 64'(obs_q.size()), 64'd32);
    if (obs_q.size() == 32) check("t4_w16", 64'(obs_q[16]), 64'h7000);

    // 5: slot 3 has bit 20 set; one extra line must stay in the FIFO
    l = make_line(32'h0);
    l[3*SW +: SW] = 32'h0010_0005;
    line_q.push_back(l);
    line_q.push_back(make_line(32'h8000));
    start(1);
    wait_done("t5", 100);
    check("t5_trunc", 64'(trunc_err), 64'd1);
    if (obs_q.size() > 3) check("t5_w3", 64'(obs_q[3]), 64'h00005);
    check("t5_left", 64'(line_q.size()), 64'd1);
    start(1);
    wait_done("t5b", 100);
    check("t5b_trunc", 64'(trunc_err), 64'd0);
    if (obs_q.size() > 0) check("t5b_w0", 64'(obs_q[0]), 64'h8000);

    // 6: zero lines
    line_q.push_back(make_line(32'h9000));
    start(0);
    @(negedge clk);
    check("t6_done", 64'(done), 64'd1);
    check("t6_pops", 64'(pops_seen), 64'd0);
    check("t6_left", 64'(line_q.size()), 64'd1);
    line_q.delete();

    // 7: reset mid-line, then clean restart
    line_q.push_back(make_line(32'hA000));
    start(1);
    wait_words("t7", 7, 100);
    @(posedge clk); #3;
    rst = 1'b0;
    line_q.delete();
    #1;
    check("t7_rd_en", 64'(dma_rd_en), 64'd0);
    check("t7_valid", 64'(out_valid), 64'd0);
    check("t7_data",  64'(out_data),  64'd0);
    check("t7_busy",  64'(busy),      64'd0);
    check("t7_done",  64'(done),      64'd0);
    check("t7_trunc", 64'(trunc_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    line_q.push_back(make_line(32'hB000));
    start(1);
    wait_done("t7b", 100);
    check("t7b_pops", 64'(pops_seen), 64'd1);
    check("t7b_count", 64'(obs_q.size()), 64'd16);
    if (obs_q.size() == 16) check("t7b_w15", 64'(obs_q[15]), 64'hB00F);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
